cdc_req_tx: RTL and testbench
=============================

CDC_REQ_TX -- requirements
Module: cdc_req_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of transferred word.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: flops in async_ack synchronizer chain.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, minimum 4: max cycles in REQ_HI before abort.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 tx_data  input  DATA_WIDTH  word to send.
REQ-007 tx_valid  input  1  local request to send tx_data.
REQ-008 tx_ready  output  1  block can accept a word this cycle.
REQ-009 async_ack  input  1  acknowledge from the far domain; asynchronous to clk.
REQ-010 async_req  output  1  four-phase request level to the far domain; registered.
REQ-011 async_data  output  DATA_WIDTH  held data bus to the far domain; registered.
REQ-012 done  output  1  one-cycle pulse: handshake completed.
REQ-013 timeout_err  output  1  sticky flag: a handshake aborted on timeout.

Function
REQ-014 async_ack SHALL pass through a SYNC_STAGES flop chain; only the last stage (ack_s) SHALL be used by logic.
REQ-015 FSM states SHALL be IDLE, REQ_HI and REQ_LO.
REQ-016 tx_ready SHALL be 1 only when state is IDLE and ack_s is 0; tx_ready is combinational from registered state.
REQ-017 Accept SHALL occur when tx_valid and tx_ready are both 1 at an edge. That edge captures tx_data into async_data, sets async_req to 1 and enters REQ_HI.
REQ-018 tx_valid while tx_ready is 0 SHALL be ignored; no word is queued.
REQ-019 In REQ_HI, when ack_s is 1 the block SHALL clear async_req on the next edge and enter REQ_LO.
REQ-020 In REQ_LO, when ack_s is 0 the block SHALL enter IDLE and pulse done for exactly one cycle.
REQ-021 async_data SHALL remain constant from the accept edge until the return to IDLE; in IDLE it holds its last value.
REQ-022 async_req SHALL change only on accept (0 to 1), on exit from REQ_HI (1 to 0), or on reset; no glitches.
REQ-023 A timeout counter SHALL clear on entry to REQ_HI and increment each cycle in REQ_HI.
REQ-024 When the counter reaches TIMEOUT_CYCLES-1 with ack_s still 0:
- async_req clears on that edge
- timeout_err sets
- state enters REQ_LO
- done does not pulse for the aborted transfer.
REQ-025 If ack_s is 1 on the same edge the counter reaches its limit, the ack SHALL win: normal REQ_LO entry, timeout_err unchanged.
REQ-026 timeout_err SHALL be cleared only by rst.
REQ-027 If ack_s is 1 while in IDLE (stale ack), the block SHALL stay in IDLE with tx_ready at 0 until ack_s is 0.
REQ-028 Minimum accept-to-done latency SHALL be 2*SYNC_STAGES+2 cycles with an immediate far-side ack; back-to-back accepts are separated by at least one IDLE cycle.

Reset
REQ-029 While rst is 1 at an edge, the following SHALL be cleared on that edge, regardless of state:
- state to IDLE
- async_req 0, async_data 0, done 0, timeout_err 0
- timeout counter 0, synchronizer flops 0.
REQ-030 Reset asserted mid-handshake SHALL abandon the transfer without a done pulse; async_req reads 0 the cycle after the reset edge.
REQ-031 Outputs SHALL be defined, with no X, from the first edge with rst at 1.

Verification
REQ-032 Normal transfer: SYNC_STAGES=2, tx_data=0xA5 with tx_valid for 1 cycle; far model raises ack 1 cycle after req and drops it 1 cycle after req falls.
- async_data=0xA5 and async_req=1 the cycle after accept.
- done pulses once; tx_ready returns to 1.
REQ-033 Back-to-back sends: tx_valid held high with 0x11 then 0x22.
- Exactly two handshakes in order.
- tx_ready is 0 throughout each handshake.
- async_data never changes while async_req=1.
REQ-034 Timeout: TIMEOUT_CYCLES=8, async_ack tied 0, accept 0x3C.
- async_req falls after 8 cycles in REQ_HI.
- timeout_err=1, no done; next accept succeeds once ack works.
REQ-035 Reset mid-operation: assert rst for 1 cycle while in REQ_HI.
- Next cycle async_req=0, async_data=0, timeout_err=0, no done.
- tx_ready=1 once ack_s is 0.
REQ-036 Stale ack: async_ack=1 out of reset for 5 cycles with tx_valid=1.
- tx_ready stays 0 and no accept occurs.
- Accept occurs the first cycle ack_s is 0.
REQ-037 Ack/timeout collision: ack_s rises on exactly the limit cycle.
- Normal completion with done pulse; timeout_err stays 0.

Source files
------------

// File: rtl/cdc_req_tx.sv
// cdc_req_tx
//   Four-phase request/acknowledge sender. A word accepted on the local side
//   is held on async_data while async_req is raised toward the far domain.
//   The far-side acknowledge comes back through a flop synchronizer. The
//   handshake completes when ack rises and then falls again. If ack never
//   arrives, the request is dropped after TIMEOUT_CYCLES and a sticky error
//   flag is set.
//
// Parameters
//   DATA_WIDTH      width of the transferred word
//   SYNC_STAGES     flops in the async_ack synchronizer (2 or more)
//   TIMEOUT_CYCLES  cycles allowed in REQ_HI before the request is aborted (4 or more)
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   tx_data      word to send
//   tx_valid     local request to send tx_data
//   tx_ready     block accepts a word this cycle
//   async_ack    acknowledge from the far domain, asynchronous to clk
//   async_req    registered four-phase request level
//   async_data   registered data bus, held for the whole handshake
//   done         one-cycle pulse when a handshake completes normally
//   timeout_err  sticky: a handshake was aborted on timeout
//
// state  | meaning
// IDLE   | waiting for tx_valid; a stale ack blocks tx_ready
// REQ_HI | async_req high, waiting for ack_s to rise or for the timeout
// REQ_LO | async_req low, waiting for ack_s to fall
module cdc_req_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  async_ack,
  output logic                  async_req,
  output logic [DATA_WIDTH-1:0] async_data,
  output logic                  done,
  output logic                  timeout_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ_HI = 2'd1;
  localparam logic [1:0] REQ_LO = 2'd2;

  localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic                   aborted;
  logic                   accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], async_ack};
    end
  end

  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign tx_ready = (state == IDLE) && !ack_s;
  assign accept   = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      async_req   <= 1'b0;
      async_data  <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      aborted     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            async_data <= tx_data;
            async_req  <= 1'b1;
            cnt        <= '0;
            aborted    <= 1'b0;
            state      <= REQ_HI;
          end
        end
        REQ_HI: begin
          // A late ack on the limit cycle still counts as a normal completion.
          if (ack_s) begin
            async_req <= 1'b0;
            state     <= REQ_LO;
          end else if (cnt == CNT_LIMIT) begin
            async_req   <= 1'b0;
            timeout_err <= 1'b1;
            aborted     <= 1'b1;
            state       <= REQ_LO;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REQ_LO: begin
          // The far side may still be acknowledging an aborted request, so
          // wait for ack_s low either way. Only a clean handshake reports done.
          if (!ack_s) begin
            done  <= !aborted;
            state <= IDLE;
          end
        end
        default: begin
          async_req <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_req_tx.sv
module tb_cdc_req_tx;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       async_ack;
  logic       async_req;
  logic [7:0] async_data;
  logic       done;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;

  cdc_req_tx #(
    .DATA_WIDTH(8),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .async_ack(async_ack),
    .async_req(async_req),
    .async_data(async_data),
    .done(done),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Main stimulus acts 1 time unit after the falling edge, so the monitor and
  // the far-side model (which act exactly on the falling edge) have settled.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Far-side model: raises ack raise_at cycles after it first sees req high
  // (0 = never), drops ack one cycle after req falls. Manual mode leaves
  // async_ack to the main process.
  bit far_manual = 1'b1;
  int raise_at   = 1;
  int req_age    = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (far_manual) begin
        req_age = 0;
      end else if (async_req) begin
        req_age++;
        if (raise_at > 0 && req_age >= raise_at) async_ack = 1'b1;
      end else begin
        req_age   = 0;
        async_ack = 1'b0;
      end
    end
  end

  // Scoreboard: every word the bench expects to be sent is queued when it is
  // driven; each rising async_req pops one and the popped value must then be
  // held on async_data for the whole request phase.
  logic [7:0] exp_q[$];
  logic [7:0] cur_exp  = 8'h00;
  logic       req_prev = 1'b0;
  int         rise_cnt = 0;
  int         done_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (async_req) begin
        chk("ready_busy", tx_ready, 0);
        if (!req_prev) begin
          rise_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual=%0h required=none", async_data);
          end else begin
            cur_exp = exp_q.pop_front();
            chk("sb_data", async_data, cur_exp);
          end
        end else begin
          chk("data_hold", async_data, cur_exp);
        end
      end
      req_prev = async_req;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    int         raise;
    int         exp_req;
    bit         exp_done;
    int         exp_lat;
    bit         exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic wait_ready(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(name, ok, 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int req_n  = 0;
    int done_n = 0;
    int done_k = -1;
    wait_ready($sformatf("v%0d_ready_wait", idx));
    raise_at = v.raise;
    tx_data  = v.data;
    tx_valid = 1'b1;
    exp_q.push_back(v.data);
    for (int k = 0; k < 24; k++) begin
      step();
      if (k == 0) tx_valid = 1'b0;
      if (async_req) req_n++;
      if (done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
    end
    chk($sformatf("v%0d_req_cycles", idx), req_n, v.exp_req);
    chk($sformatf("v%0d_done_count", idx), done_n, v.exp_done ? 1 : 0);
    if (v.exp_done) chk($sformatf("v%0d_latency", idx), done_k, v.exp_lat);
    chk($sformatf("v%0d_timeout_err", idx), timeout_err, v.exp_err);
    chk($sformatf("v%0d_ready_after", idx), tx_ready, 1);
  endtask

  initial begin
    int base_r;
    int base_d;

    // raise r -> req high r+2 cycles, done r+5 cycles after accept.
    // Limit edge is the 8th in REQ_HI: r=6 lands ack_s exactly on it.
    vecs[0] = '{8'hA5, 1, 3, 1'b1, 6, 1'b0};
    vecs[1] = '{8'hFF, 3, 5, 1'b1, 8, 1'b0};
    vecs[2] = '{8'h5A, 5, 7, 1'b1, 10, 1'b0};
    vecs[3] = '{8'hC3, 6, 8, 1'b1, 11, 1'b0};
    vecs[4] = '{8'h96, 7, 8, 1'b0, 0, 1'b1};
    vecs[5] = '{8'h3C, 0, 8, 1'b0, 0, 1'b1};
    vecs[6] = '{8'h81, 1, 3, 1'b1, 6, 1'b1};

    rst       = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    async_ack = 1'b1;

    step();
    chk("rst_req", async_req, 0);
    chk("rst_data", async_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_ready", tx_ready, 1);
    rst = 1'b0;

    // Stale ack: let it reach ack_s, then offer a word for 5 cycles.
    step();
    step();
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stale_ready", tx_ready, 0);
      chk("stale_req", async_req, 0);
    end
    async_ack = 1'b0;
    exp_q.push_back(8'h77);
    step();
    chk("stale_ready_sync1", tx_ready, 0);
    step();
    chk("stale_ready_clear", tx_ready, 1);
    chk("stale_req_pre", async_req, 0);
    step();
    chk("stale_accept", async_req, 1);
    tx_valid   = 1'b0;
    raise_at   = 1;
    far_manual = 1'b0;
    base_d     = done_cnt;
    repeat (12) step();
    chk("stale_done", done_cnt - base_d, 1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Back-to-back with tx_valid held high.
    wait_ready("b2b_ready_wait");
    raise_at = 1;
    base_r   = rise_cnt;
    base_d   = done_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    tx_data  = 8'h11;
    tx_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (rise_cnt - base_r >= 1) tx_data = 8'h22;
      if (rise_cnt - base_r >= 2) break;
    end
    tx_valid = 1'b0;
    repeat (12) step();
    chk("b2b_rises", rise_cnt - base_r, 2);
    chk("b2b_dones", done_cnt - base_d, 2);

    // Reset during REQ_HI; timeout_err is still set from the earlier abort.
    wait_ready("rst_mid_ready_wait");
    raise_at = 0;
    exp_q.push_back(8'h5A);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    chk("rst_mid_req_before", async_req, 1);
    step();
    step();
    rst    = 1'b1;
    base_d = done_cnt;
    step();
    rst = 1'b0;
    chk("rst_mid_req", async_req, 0);
    chk("rst_mid_data", async_data, 0);
    chk("rst_mid_err", timeout_err, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_ready", tx_ready, 1);
    repeat (10) step();
    chk("rst_mid_no_done", done_cnt - base_d, 0);
    chk("rst_mid_req_idle", async_req, 0);

    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
